clk_div_bank: RTL and testbench

Parametrised bank of `NCH` independent integer clock dividers, each producing a 50%-duty (odd: high-biased) divided clock and a one-cycle clock-enable tick in the `clk` domain. Each channel's divisor is runtime-reloadable, glitch-free, at its period boundary. A global enable and a sync strobe are provided. It replaces fixed power-of-two counter taps feeding the VGA controller and block memories, and adds game-logic tick generation (sprite movement, animation) with software-chosen rates.

---
 rtl/clk_div_bank.sv | 95 +++++++++
 tb/tb_clk_div_bank.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Bank of NCH independent integer clock dividers with 50%-duty (odd: high-biased)
// outputs, per-period ticks and divisor reloads applied only at period boundaries.
module clk_div_bank #(
  parameter int NCH         = 2,
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sync,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] div_in,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       pend,
  output logic [NCH-1:0]       load_err
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt, div, pdiv;
    logic [WIDTH-1:0] cnt_nx, div_nx, pdiv_nx;
    logic [WIDTH-1:0] slice;
    logic             pend_q, pend_nx;
    logic             clk_q, clk_nx;
    logic             last_q, last_nx;
    logic             err_q, err_nx;
    logic             valid, wrap;

    assign slice = div_in[i*WIDTH +: WIDTH];
    assign valid = load[i] && (slice >= MIN_DIV);
    assign wrap  = en && !sync && (cnt == div - WIDTH'(1));

    // Sync and the natural wrap share one boundary path: a same-cycle load beats
    // an older pending divisor, and the pending flag never survives a boundary.
    always_comb begin
      cnt_nx  = cnt;
      div_nx  = div;
      pdiv_nx = pdiv;
      pend_nx = pend_q;
      if (sync || wrap) begin
        cnt_nx = '0;
        if (valid) begin
          div_nx = slice;
        end else if (pend_q) begin
          div_nx = pdiv;
        end
        pdiv_nx = div_nx;
        pend_nx = 1'b0;
      end else begin
        if (en) begin
          cnt_nx = cnt + WIDTH'(1);
        end
        if (valid) begin
          pdiv_nx = slice;
          pend_nx = 1'b1;
        end
      end
      // Output flags are precomputed from the next state so they leave flops directly.
      clk_nx  = (cnt_nx >= (div_nx >> 1));
      last_nx = (cnt_nx == div_nx - WIDTH'(1));
      err_nx  = load[i] && (slice < MIN_DIV);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt    <= '0;
        div    <= DEF_DIV;
        pdiv   <= DEF_DIV;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        last_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        cnt    <= cnt_nx;
        div    <= div_nx;
        pdiv   <= pdiv_nx;
        pend_q <= pend_nx;
        clk_q  <= clk_nx;
        last_q <= last_nx;
        err_q  <= err_nx;
      end
    end

    // Tick is qualified by the live enable and suppressed on a sync cycle.
    assign tick[i]     = last_q && en && !sync;
    assign clk_out[i]  = clk_q;
    assign pend[i]     = pend_q;
    assign load_err[i] = err_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios plus random traffic,
// all checked each cycle against a cycle-level reference model of the dividers.
module tb_clk_div_bank;
  localparam int NCH         = 2;
  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic                 sync = 1'b0;
  logic [NCH-1:0]       load = '0;
  logic [NCH*WIDTH-1:0] div_in = '0;
  logic [NCH-1:0]       clk_out, tick, pend, load_err;

  int checks = 0;
  int failures = 0;

  int m_cnt [NCH];
  int m_div [NCH];
  int m_pdiv[NCH];
  bit m_pend[NCH];
  bit m_lerr[NCH];
  bit m_valid = 1'b0;

  clk_div_bank #(.NCH(NCH), .WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .load(load), .div_in(div_in),
    .clk_out(clk_out), .tick(tick), .pend(pend), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [NCH-1:0] obs,
                             input logic [NCH-1:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input bit r, input bit e, input bit s,
                               input logic [NCH-1:0] ld, input int d0, input int d1);
    logic [NCH-1:0] e_clk, e_tick, e_pend, e_err;
    int d[NCH];
    d[0] = d0;
    d[1] = d1;
    rst_n  = r;
    en     = e;
    sync   = s;
    load   = ld;
    div_in = {WIDTH'(d1), WIDTH'(d0)};
    #4;
    if (m_valid && r) begin
      for (int i = 0; i < NCH; i++) begin
        e_clk[i]  = (m_cnt[i] >= m_div[i] / 2);
        e_tick[i] = e && !s && (m_cnt[i] == m_div[i] - 1);
        e_pend[i] = m_pend[i];
        e_err[i]  = m_lerr[i];
      end
      checkOutput("clk_out", clk_out, e_clk);
      checkOutput("tick", tick, e_tick);
      checkOutput("pend", pend, e_pend);
      checkOutput("load_err", load_err, e_err);
    end
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      bit ok;
      ok = ld[i] && (d[i] >= 2);
      if (!r) begin
        m_cnt[i]  = 0;
        m_div[i]  = DEFAULT_DIV;
        m_pdiv[i] = DEFAULT_DIV;
        m_pend[i] = 1'b0;
        m_lerr[i] = 1'b0;
      end else begin
        m_lerr[i] = ld[i] && (d[i] < 2);
        if (s || (e && m_cnt[i] == m_div[i] - 1)) begin
          if (ok) m_div[i] = d[i];
          else if (m_pend[i]) m_div[i] = m_pdiv[i];
          m_pend[i] = 1'b0;
          m_cnt[i]  = 0;
        end else begin
          if (e) m_cnt[i] = m_cnt[i] + 1;
          if (ok) begin
            m_pdiv[i] = d[i];
            m_pend[i] = 1'b1;
          end
        end
      end
    end
    if (!r) m_valid = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1, 1, 0, '0, 0, 0);
  endtask

  // Runs until the model counter of channel ch equals value; timeout counts as a failure.
  task automatic waitCount(input int ch, input int value);
    bit reached;
    reached = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_cnt[ch] == value) begin
        reached = 1'b1;
        break;
      end
      applyStimulus(1, 1, 0, '0, 0, 0);
    end
    checkOutput("wait_count", NCH'(reached), NCH'(1));
  endtask

  initial begin
    applyStimulus(0, 0, 0, '0, 0, 0);
    applyStimulus(0, 1, 0, '0, 0, 0);
    idle(12);

    // Odd divisor loaded mid-period on channel 0.
    waitCount(0, 1);
    applyStimulus(1, 1, 0, 2'b01, 5, 0);
    idle(15);

    // Load on channel 1's wrap cycle, then back-to-back loads.
    waitCount(1, m_div[1] - 1);
    applyStimulus(1, 1, 0, 2'b10, 0, 3);
    idle(6);
    waitCount(1, 0);
    applyStimulus(1, 1, 0, 2'b10, 0, 7);
    applyStimulus(1, 1, 0, 2'b10, 0, 9);
    idle(22);

    // Rejected loads.
    applyStimulus(1, 1, 0, 2'b01, 1, 0);
    applyStimulus(1, 1, 0, 2'b01, 0, 0);
    idle(10);

    // Enable low with a load accepted while frozen.
    waitCount(0, 2);
    applyStimulus(1, 0, 0, 2'b01, 6, 0);
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, '0, 0, 0);
    idle(15);

    // Sync with a pending divisor, then reset mid-operation.
    waitCount(0, 1);
    applyStimulus(1, 1, 0, 2'b01, 10, 0);
    idle(1);
    applyStimulus(1, 1, 1, '0, 0, 0);
    idle(14);
    applyStimulus(1, 1, 0, 2'b11, 7, 11);
    applyStimulus(0, 1, 0, '0, 0, 0);
    idle(10);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      bit r, e, s;
      logic [NCH-1:0] ld;
      r = ($urandom_range(0, 99) >= 1);
      e = ($urandom_range(0, 99) < 85);
      s = ($urandom_range(0, 99) < 3);
      ld[0] = ($urandom_range(0, 99) < 15);
      ld[1] = ($urandom_range(0, 99) < 15);
      applyStimulus(r, e, s, ld, $urandom_range(0, 12), $urandom_range(0, 12));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
